// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces five raw keys, then derives menu short/long, gear and clean pulses.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 300000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       menu_btn,
    input  logic [2:0] speed_btn,
    input  logic       clean_btn,
    output logic       menu_short,
    output logic       menu_long,
    output logic [2:0] speed_sel,
    output logic       clean_pulse,
    output logic [4:0] keys_held
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {IDLE, HOLD, LONG} state_t;

    logic [4:0]         sync1_q, sync2_q, stable_q, stable_d, prev_q, rise;
    logic [4:0][DW-1:0] cnt_q, cnt_d;
    logic [2:0]         speed_rise, speed_sel_d, speed_sel_q;
    logic               clean_pulse_d, clean_pulse_q;
    logic               short_d, short_q, long_d, long_q;
    logic [HW-1:0]      hold_d, hold_q;
    state_t             state_d, state_q;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_LAST) stable_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // prev_q lags stable_q by one cycle so every pulse lands the edge after the stable change
    assign rise          = stable_q & ~prev_q;
    assign speed_rise    = rise[3:1];
    assign speed_sel_d   = ((speed_rise & (speed_rise - 3'd1)) == 3'd0) ? speed_rise : 3'd0;
    assign clean_pulse_d = rise[4];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        unique case (state_q)
            IDLE: if (stable_q[0]) begin
                hold_d  = HW'(1);
                long_d  = (LONG_PRESS_CYCLES <= 1);
                state_d = (LONG_PRESS_CYCLES <= 1) ? LONG : HOLD;
            end
            HOLD: if (!stable_q[0]) begin
                short_d = 1'b1;
                hold_d  = '0;
                state_d = IDLE;
            end else if (hold_q >= HOLD_LAST) begin
                long_d  = 1'b1;
                hold_d  = HOLD_MAX;
                state_d = LONG;
            end else begin
                hold_d  = hold_q + 1'b1;
            end
            LONG: if (!stable_q[0]) begin
                hold_d  = '0;
                state_d = IDLE;
            end
            default: begin
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            prev_q        <= '0;
            cnt_q         <= '0;
            speed_sel_q   <= '0;
            clean_pulse_q <= 1'b0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            hold_q        <= '0;
            state_q       <= IDLE;
        end else begin
            sync1_q       <= {clean_btn, speed_btn, menu_btn};
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            prev_q        <= stable_q;
            cnt_q         <= cnt_d;
            speed_sel_q   <= speed_sel_d;
            clean_pulse_q <= clean_pulse_d;
            short_q       <= short_d;
            long_q        <= long_d;
            hold_q        <= hold_d;
            state_q       <= state_d;
        end
    end

    assign keys_held   = stable_q;
    assign speed_sel   = speed_sel_q;
    assign clean_pulse = clean_pulse_q;
    assign menu_short  = short_q;
    assign menu_long   = long_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce timing, pulse generation and menu short/long handling.
module tb_key_conditioner;
    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0, reset = 1'b0, menu_btn = 1'b0, clean_btn = 1'b0;
    logic [2:0] speed_btn = 3'd0;
    logic       menu_short, menu_long, clean_pulse;
    logic [2:0] speed_sel;
    logic [4:0] keys_held;
    int         n_checks = 0, n_errors = 0;

    key_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
        .clk(clk), .reset(reset), .menu_btn(menu_btn), .speed_btn(speed_btn),
        .clean_btn(clean_btn), .menu_short(menu_short), .menu_long(menu_long),
        .speed_sel(speed_sel), .clean_pulse(clean_pulse), .keys_held(keys_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_held"}, keys_held, 0);
        check({tag, "_sel"}, speed_sel, 0);
        check({tag, "_clean"}, clean_pulse, 0);
        check({tag, "_short"}, menu_short, 0);
        check({tag, "_long"}, menu_long, 0);
    endtask

    initial begin
        repeat (3) tick;
        check_idle("rst");
        reset = 1'b1;
        repeat (3) tick;
        check_idle("post_rst");

        clean_btn = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick;
            check("clean_held", keys_held[4], e >= 6);
            check("clean_pulse", clean_pulse, e == 7);
            check("clean_sel", speed_sel, 0);
        end
        clean_btn = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick;
            check("clean_rel_held", keys_held[4], e < 6);
            check("clean_rel_pulse", clean_pulse, 0);
        end

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 6; c++) begin
                speed_btn = (c < 3) ? 3'b010 : 3'b000;
                tick;
                check("bounce_sel", speed_sel, 0);
                check("bounce_held", keys_held[3:1], 0);
            end
        speed_btn = 3'b000;
        repeat (4) tick;
        check("bounce_final", keys_held, 0);

        speed_btn = 3'b101;
        for (int e = 1; e <= 10; e++) begin
            tick;
            check("multi_sel", speed_sel, 0);
            check("multi_held", keys_held[3:1], e >= 6 ? 5 : 0);
        end
        speed_btn = 3'b111;
        for (int e = 1; e <= 10; e++) begin
            tick;
            check("single_sel", speed_sel, e == 7 ? 2 : 0);
            check("single_held", keys_held[3:1], e >= 6 ? 7 : 5);
        end
        speed_btn = 3'b000;
        for (int e = 1; e <= 10; e++) begin
            tick;
            check("speed_rel_sel", speed_sel, 0);
        end
        check("speed_rel_held", keys_held, 0);

        clean_btn = 1'b1;
        speed_btn = 3'b001;
        for (int e = 1; e <= 10; e++) begin
            tick;
            check("sim_clean", clean_pulse, e == 7);
            check("sim_sel", speed_sel, e == 7 ? 1 : 0);
        end
        clean_btn = 1'b0;
        speed_btn = 3'b000;
        repeat (10) tick;
        check_idle("sim_rel");

        for (int e = 1; e <= 55; e++) begin
            menu_btn = (e <= 40);
            tick;
            check("long_held", keys_held[0], e >= 6 && e < 46);
            check("long_pulse", menu_long, e == 26);
            check("long_short", menu_short, 0);
        end

        for (int e = 1; e <= 25; e++) begin
            menu_btn = (e <= 10);
            tick;
            check("short_held", keys_held[0], e >= 6 && e < 16);
            check("short_pulse", menu_short, e == 17);
            check("short_long", menu_long, 0);
        end

        menu_btn = 1'b1;
        for (int e = 1; e <= 8; e++) tick;
        check("pre_rst_held", keys_held[0], 1);
        reset = 1'b0;
        #1;
        check_idle("mid_rst");
        repeat (2) begin
            tick;
            check_idle("mid_rst_hold");
        end
        reset = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick;
            check("rel_held", keys_held[0], e >= 6);
            check("rel_long", menu_long, e == 26);
            check("rel_short", menu_short, 0);
        end
        menu_btn = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick;
            check("rel_end_short", menu_short, 0);
            check("rel_end_long", menu_long, 0);
        end
        check("rel_end_held", keys_held, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the consecutive cycles a synchronized key level must differ from its stable level before the stable level changes.
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 300000000, meaning the stable-high cycles of menu_btn that qualify as a long press.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port menu_btn, input, 1 bit: raw menu key, high = pressed.
REQ-006 The block SHALL have port speed_btn, input, 3 bits: raw speed keys, bit0 = gear 1, bit1 = gear 2, bit2 = gear 3, high = pressed.
REQ-007 The block SHALL have port clean_btn, input, 1 bit: raw self-clean key, high = pressed.
REQ-008 The block SHALL have port menu_short, output, 1 bit: one-cycle pulse indicating a short menu press, emitted on release.
REQ-009 The block SHALL have port menu_long, output, 1 bit: one-cycle pulse emitted when the menu hold reaches LONG_PRESS_CYCLES.
REQ-010 The block SHALL have port speed_sel, output, 3 bits: one-hot one-cycle pulse identifying a newly pressed gear key.
REQ-011 The block SHALL have port clean_pulse, output, 1 bit: one-cycle pulse indicating a new clean-key press.
REQ-012 The block SHALL have port keys_held, output, 5 bits: stable levels {clean, speed[2:0], menu}, bit0 = menu.

Function
REQ-013 Each of the 5 raw keys SHALL pass through an independent 2-flop synchronizer before any other logic.
REQ-014 Each key SHALL have its own debounce counter and stable register.
- Counter clears on every edge where the synchronized level equals the stable level.
- Counter increments on every edge where the levels differ.
- On the DEBOUNCE_CYCLES-th consecutive differing edge, the stable register takes the synchronized level and the counter clears.
REQ-015 A raw disturbance lasting fewer than DEBOUNCE_CYCLES cycles SHALL NOT change any stable level or produce any pulse.
REQ-016 keys_held SHALL equal the stable registers directly; a raw change held steadily SHALL appear on keys_held after edge 2+DEBOUNCE_CYCLES, counted from the first edge that samples the new raw level.
REQ-017 All pulse outputs SHALL be registered and high for exactly one cycle, starting the edge after the triggering stable-register change (edge 3+DEBOUNCE_CYCLES).
REQ-018 clean_pulse SHALL fire on a 0->1 transition of the stable clean level only.
REQ-019 speed_sel SHALL carry the bits whose stable speed level rose 0->1 in the same cycle, subject to these rules:
- If exactly one bit rose, speed_sel is that bit.
- If more than one bit rose in the same cycle, speed_sel SHALL stay 000.
- Keys already held do not affect a new single rise.
REQ-020 The menu logic SHALL be a 3-state FSM:
- IDLE: stable menu high -> HOLD, with the hold counter loaded to 1.
- HOLD: hold counter increments each cycle.
  - Stable menu falls before the count reaches LONG_PRESS_CYCLES -> menu_short pulse, go to IDLE.
  - Count reaches LONG_PRESS_CYCLES -> menu_long pulse, go to LONG.
- LONG: hold counter frozen, no pulses; stable menu falls -> IDLE, with no menu_short.
REQ-021 menu_short and menu_long SHALL never be high in the same cycle, and each menu hold SHALL produce exactly one of them.
REQ-022 Counters SHALL be sized to hold their parameter value without wrap; the hold counter SHALL saturate and never wrap.
REQ-023 Simultaneous events on different keys SHALL be handled independently; pulses on different outputs MAY coincide.

Reset
REQ-024 While reset is low, the following SHALL be 0 or cleared: all synchronizers, debounce counters, stable registers, the hold counter, keys_held, speed_sel, menu_short, menu_long and clean_pulse; the FSM SHALL be in IDLE.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse emitted.
REQ-026 A key held through reset release SHALL be treated as a new press and qualified by the full debounce after release.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-027 Verification SHALL cover: clean_btn 0->1 held steady -> keys_held[4]=1 after edge 6; clean_pulse=1 for exactly the cycle after edge 7; no further pulse while held.
REQ-028 Verification SHALL cover: speed_btn bit1 toggling high for 3 cycles then low, repeated 5 times -> speed_sel stays 000 and keys_held[3:1] stays 000 throughout.
REQ-029 Verification SHALL cover: menu held 10 stable cycles then released -> one menu_short pulse after the stable fall; menu_long stays 0.
REQ-030 Verification SHALL cover: menu held 40 cycles -> menu_long pulses once, when the hold count reaches 20; menu_short stays 0 after release; FSM returns to IDLE.
REQ-031 Verification SHALL cover: speed_btn 000->101 in one cycle -> speed_sel stays 000; bit1 then pressed alone -> speed_sel=010 for one cycle.
REQ-032 Verification SHALL cover: reset driven low 2 cycles after menu becomes stable-high, menu still held -> all outputs 0 during reset; after release, keys_held[0]=1 after edge 6; menu_long fires once 20 cycles later.
